hog_block_buffer: RTL and testbench

Gathers the per-cell 9-bin gradient histograms produced in raster order and assembles overlapping 2x2-cell blocks (stride one cell) for the normalization stage. It keeps one row of cell histograms in a row buffer plus two previous-cell registers. For every cell at row r ≥ 1 and column c ≥ 1 it emits one block (a = top-left, b = top-right, c = bottom-left, d = bottom-right), which drives the normalizer's `i_bin_a..d` / `i_valid` inputs directly.

---
 rtl/hog_block_buffer_if.sv | 31 +++
 rtl/hog_block_buffer.sv | 119 +++++++++++
 tb/tb_hog_block_buffer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/hog_block_buffer_if.sv
// Cell-histogram in / 2x2 block out bundle for the HOG block buffer.
// slave = the buffer itself, master = the upstream cell source and downstream sink.
interface hog_block_buffer_if #(
  parameter int BIN_I = 16,
  parameter int BIN_F = 16,
  parameter int COL_W = 5,
  parameter int ROW_W = 4
);
  localparam int W = BIN_I + BIN_F;

  logic [9*W-1:0]   i_bin;
  logic             i_valid;
  logic [9*W-1:0]   o_bin_a;
  logic [9*W-1:0]   o_bin_b;
  logic [9*W-1:0]   o_bin_c;
  logic [9*W-1:0]   o_bin_d;
  logic             o_valid;
  logic [COL_W-1:0] o_blk_col;
  logic [ROW_W-1:0] o_blk_row;
  logic             o_frame_done;

  modport master (
    output i_bin, i_valid,
    input  o_bin_a, o_bin_b, o_bin_c, o_bin_d, o_valid, o_blk_col, o_blk_row, o_frame_done
  );

  modport slave (
    input  i_bin, i_valid,
    output o_bin_a, o_bin_b, o_bin_c, o_bin_d, o_valid, o_blk_col, o_blk_row, o_frame_done
  );
endinterface

// File: rtl/hog_block_buffer.sv
// Assembles overlapping 2x2 cell blocks from raster-order cell histograms.
// Latency 1 cycle from the d-cell's i_valid; no backpressure, one cell per cycle.
module hog_block_buffer #(
  parameter int BIN_I     = 16,
  parameter int BIN_F     = 16,
  parameter int CELL_COLS = 20,
  parameter int CELL_ROWS = 15,
  parameter int COL_W     = 5,
  parameter int ROW_W     = 4
) (
  input logic              clk,
  input logic              rst,
  hog_block_buffer_if.slave bus
);
  localparam int W  = BIN_I + BIN_F;
  localparam int BW = 9 * W;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(CELL_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CELL_ROWS - 1);

  logic [BW-1:0]    mem_q [CELL_COLS];
  logic [BW-1:0]    top_rd;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [BW-1:0]    prev_top_q, prev_top_d;
  logic [BW-1:0]    prev_cur_q, prev_cur_d;
  logic [BW-1:0]    bin_a_q, bin_a_d;
  logic [BW-1:0]    bin_b_q, bin_b_d;
  logic [BW-1:0]    bin_c_q, bin_c_d;
  logic [BW-1:0]    bin_d_q, bin_d_d;
  logic [COL_W-1:0] blk_col_q, blk_col_d;
  logic [ROW_W-1:0] blk_row_q, blk_row_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;

  // Old contents of the column slot: the cell directly above the incoming one.
  assign top_rd = mem_q[col_q];

  // Never cleared; row 0 of every frame overwrites before anything reads it as a top cell.
  always_ff @(posedge clk) begin
    if (rst && bus.i_valid) begin
      mem_q[col_q] <= bus.i_bin;
    end
  end

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    prev_top_d = prev_top_q;
    prev_cur_d = prev_cur_q;
    bin_a_d    = bin_a_q;
    bin_b_d    = bin_b_q;
    bin_c_d    = bin_c_q;
    bin_d_d    = bin_d_q;
    blk_col_d  = blk_col_q;
    blk_row_d  = blk_row_q;
    vld_d      = 1'b0;
    done_d     = 1'b0;
    if (bus.i_valid) begin
      prev_top_d = top_rd;
      prev_cur_d = bus.i_bin;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (col_q != '0 && row_q != '0) begin
        bin_a_d   = prev_top_q;
        bin_b_d   = top_rd;
        bin_c_d   = prev_cur_q;
        bin_d_d   = bus.i_bin;
        blk_col_d = col_q - 1'b1;
        blk_row_d = row_q - 1'b1;
        vld_d     = 1'b1;
        done_d    = (col_q == COL_LAST) && (row_q == ROW_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q      <= '0;
      row_q      <= '0;
      prev_top_q <= '0;
      prev_cur_q <= '0;
      bin_a_q    <= '0;
      bin_b_q    <= '0;
      bin_c_q    <= '0;
      bin_d_q    <= '0;
      blk_col_q  <= '0;
      blk_row_q  <= '0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      prev_top_q <= prev_top_d;
      prev_cur_q <= prev_cur_d;
      bin_a_q    <= bin_a_d;
      bin_b_q    <= bin_b_d;
      bin_c_q    <= bin_c_d;
      bin_d_q    <= bin_d_d;
      blk_col_q  <= blk_col_d;
      blk_row_q  <= blk_row_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_bin_a      = bin_a_q;
  assign bus.o_bin_b      = bin_b_q;
  assign bus.o_bin_c      = bin_c_q;
  assign bus.o_bin_d      = bin_d_q;
  assign bus.o_blk_col    = blk_col_q;
  assign bus.o_blk_row    = blk_row_q;
  assign bus.o_valid      = vld_q;
  assign bus.o_frame_done = done_q;
endmodule

// File: tb/tb_hog_block_buffer.sv
// Scoreboard bench for hog_block_buffer: directed frames push expected blocks,
// a negedge monitor pops and compares every o_valid pulse.
module tb_hog_block_buffer;
  localparam int BIN_I = 16, BIN_F = 16, CELL_COLS = 20, CELL_ROWS = 15, COL_W = 5, ROW_W = 4;
  localparam int W  = BIN_I + BIN_F;
  localparam int BW = 9 * W;
  localparam int BLKS = (CELL_ROWS - 1) * (CELL_COLS - 1);

  typedef struct {
    logic [BW-1:0] a, b, c, d;
    int            col, row;
    bit            done;
    time           t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hog_block_buffer_if #(.BIN_I(BIN_I), .BIN_F(BIN_F), .COL_W(COL_W), .ROW_W(ROW_W)) bus ();

  hog_block_buffer #(
    .BIN_I(BIN_I), .BIN_F(BIN_F), .CELL_COLS(CELL_COLS), .CELL_ROWS(CELL_ROWS),
    .COL_W(COL_W), .ROW_W(ROW_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t          q[$];
  logic [BW-1:0] img [CELL_ROWS][CELL_COLS];
  int checks = 0, errors = 0;
  int blk_cnt = 0, done_cnt = 0;

  function automatic logic [BW-1:0] cellv(input logic [W-1:0] v);
    logic [BW-1:0] r;
    for (int k = 0; k < 9; k++) r[k*W +: W] = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every o_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_valid) begin
      blk_cnt++;
      if (bus.o_frame_done) done_cnt++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_blk got row %0d col %0d expected no block", bus.o_blk_row, bus.o_blk_col);
      end else begin
        e = q.pop_front();
        chk("bin_a", bus.o_bin_a, e.a);
        chk("bin_b", bus.o_bin_b, e.b);
        chk("bin_c", bus.o_bin_c, e.c);
        chk("bin_d", bus.o_bin_d, e.d);
        chk("blk_col", BW'(bus.o_blk_col), BW'(e.col));
        chk("blk_row", BW'(bus.o_blk_row), BW'(e.row));
        chk("frame_done", BW'(bus.o_frame_done), BW'(e.done));
        chk("latency_edge", BW'($time - 5), BW'(e.t));
      end
    end else if (bus.o_frame_done) begin
      checks++; errors++;
      $display("FAIL stray_frame_done got 1 expected 0");
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cell(input int r, input int c, input int gap);
    exp_t e;
    bus.i_bin   = img[r][c];
    bus.i_valid = 1'b1;
    @(posedge clk);
    if (r >= 1 && c >= 1) begin
      e.a = img[r-1][c-1];
      e.b = img[r-1][c];
      e.c = img[r][c-1];
      e.d = img[r][c];
      e.col = c - 1;
      e.row = r - 1;
      e.done = (r == CELL_ROWS - 1) && (c == CELL_COLS - 1);
      e.t = $time;
      q.push_back(e);
    end
    #1;
    bus.i_valid = 1'b0;
    idle(gap);
  endtask

  // Sends cells of one frame up to and including (last_r, last_c).
  task automatic send_frame(input logic [W-1:0] base, input int gap_max, input int last_r, input int last_c);
    for (int r = 0; r <= last_r; r++) begin
      for (int c = 0; c < CELL_COLS; c++) begin
        if (r == last_r && c > last_c) break;
        img[r][c] = cellv(base + W'(r * 256 + c));
        send_cell(r, c, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
      end
    end
  endtask

  task automatic check_count(input string name, input int start_blk, input int start_done, input int nfr);
    idle(3);
    chk({name, "_blocks"}, BW'(blk_cnt - start_blk), BW'(nfr * BLKS));
    chk({name, "_frame_done"}, BW'(done_cnt - start_done), BW'(nfr));
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    chk({name, "_valid"}, BW'(bus.o_valid), '0);
    chk({name, "_done"}, BW'(bus.o_frame_done), '0);
    chk({name, "_col"}, BW'(bus.o_blk_col), '0);
    chk({name, "_row"}, BW'(bus.o_blk_row), '0);
    chk({name, "_bins"}, bus.o_bin_a | bus.o_bin_b | bus.o_bin_c | bus.o_bin_d, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired, outstanding blocks %0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0;
    logic [BW-1:0] spec;
    bus.i_valid = 1'b0;
    bus.i_bin   = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Frame with back-to-back cells, bins = r*256+c.
    b0 = blk_cnt; d0 = done_cnt;
    send_frame(32'h0, 0, CELL_ROWS - 1, CELL_COLS - 1);
    check_count("frame_b2b", b0, d0, 1);

    // Same frame with sparse random gaps.
    b0 = blk_cnt; d0 = done_cnt;
    send_frame(32'h0, 4, CELL_ROWS - 1, CELL_COLS - 1);
    check_count("frame_gaps", b0, d0, 1);

    // Two consecutive frames with no idle between them.
    b0 = blk_cnt; d0 = done_cnt;
    send_frame(32'h0, 0, CELL_ROWS - 1, CELL_COLS - 1);
    send_frame(32'hFFFF_0000, 0, CELL_ROWS - 1, CELL_COLS - 1);
    check_count("two_frames", b0, d0, 2);

    // Partial frame up to (5,7), then a reset cycle carrying a would-be block cell.
    send_frame(32'h0, 0, 5, 7);
    idle(1);
    rst = 1'b0;
    bus.i_bin = cellv(32'hDEAD_BEEF);
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    rst = 1'b1;
    check_reset_state("midreset");
    chk("midreset_queue", BW'(q.size()), '0);
    b0 = blk_cnt; d0 = done_cnt;
    send_frame(32'h0000_1000, 1, CELL_ROWS - 1, CELL_COLS - 1);
    check_count("after_reset", b0, d0, 1);

    // Bin order: cell (1,1) carries bin k = k+1.
    for (int k = 0; k < 9; k++) spec[k*W +: W] = W'(k + 1);
    send_frame(32'h0000_0500, 0, 1, 0);
    img[1][1] = spec;
    send_cell(1, 1, 0);
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      logic [W-1:0] kv;
      kv = W'(k + 1);
      chk($sformatf("bin_order_%0d", k), BW'(bus.o_bin_d[k*W +: W]), BW'(kv));
    end

    idle(3);
    chk("final_queue_empty", BW'(q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
